sum_stage: RTL
==============

Name: sum_stage

Overview:
- PE pipeline stage directly downstream of the multiply stage (FS -> MS -> SS).
- Consumes per-row partial-product sums (Sum_MS) and incoming partial sums (Psum_MS).
- Accumulates them across a multi-beat window into per-row signed saturating accumulators.
- Emits the finished psums, plus the passed-through post-process control, to the psum/output stage under rdy/ack.

Parameters:
- PEROW, 4, number of PE rows processed in parallel.
- ASUMDWD, 12, signed width of each row's multiplier-array sum (Sum_MS).
- PSUMDWD, 16, signed width of psum in, accumulator and psum out.
- PPCTLWD, 4, width of the post-process control word carried with the result.
- CNTWD, 8, width of the beat counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset. Synchronous, active-high.
- MS_rdy  input  1  upstream beat valid.
- MS_ack  output  1  upstream beat consumed this cycle.
- i_first  input  1  SS ctl: beat starts a new window (accumulator cleared before add).
- i_last  input  1  SS ctl: beat closes the window (result emitted).
- i_add_psum  input  1  SS ctl: add Psum_MS for this beat.
- i_ppctl  input  PPCTLWD  post-process ctl. Latched on the last beat.
- i_psum  input  PEROW*PSUMDWD  Psum_MS per row. Row r is bits [r*PSUMDWD +: PSUMDWD].
- i_sum  input  PEROW*ASUMDWD  Sum_MS per row, same packing.
- SS_rdy  output  1  result valid.
- SS_ack  input  1  downstream consumed result.
- o_psum  output  PEROW*PSUMDWD  finished psums.
- o_sat  output  PEROW  per-row sticky saturation flag for the window.
- o_ppctl  output  PPCTLWD  ctl of the last beat.
- o_beats  output  CNTWD  beats accumulated in the emitted window.

Behaviour:
- Reset (i_rst high at a clock edge) clears all state:
  - SS_rdy=0, o_psum=0, o_sat=0, o_ppctl=0, o_beats=0.
  - Accumulators, sticky flags and beat counter cleared.
  - Reset mid-window discards the partial window. Reset while SS_rdy=1 drops the pending result. No MS_ack in the reset cycle.
- Output slot "free" = !SS_rdy || SS_ack.
- MS_ack = MS_rdy && (!i_last || free). MS_ack is combinational.
  - Non-last beats are never stalled, even while a previous result is pending: the accumulator is separate from the output register.
  - A last beat stalls while the output is held. MS_rdy and all inputs must stay stable until acked.
- On an accepted beat, per row r:
  - base = i_first ? 0 : acc[r].
  - t = base + sext(sum[r]) + (i_add_psum ? psum[r] : 0), computed at PSUMDWD+2 bits.
  - Clamp t to [-2^(PSUMDWD-1), 2^(PSUMDWD-1)-1].
  - sat[r] = (i_first ? 0 : sat[r]) | clamped.
  - Clamping is per beat: a later negative beat can move a clamped value back in range.
- Beat counter: cnt = (i_first ? 1 : cnt+1). It saturates at 2^CNTWD-1.
- Accepted beat with i_last:
  - Next cycle: SS_rdy=1, o_psum=clamped t, o_sat=updated sat, o_ppctl=i_ppctl, o_beats=updated cnt.
  - Accumulator/flags/count are then don't-care until the next i_first.
  - Latency: 1 cycle from last-beat acceptance to SS_rdy.
- i_first && i_last on the same beat is a single-beat window. Result = clamp(sum + optional psum).
- SS_rdy clears on SS_ack unless a new last beat is accepted the same cycle. In that case SS_rdy stays 1 and the outputs load the new result (back-to-back, full throughput).
- Outputs are stable while SS_rdy && !SS_ack.
- A beat without i_first after a completed window continues from the stale accumulator. This is a protocol error, not checked.

Test Plan:
- Reset, then one beat with first=last=1, add_psum=1, sum row0=5, psum row0=100 -> SS_rdy next cycle, o_psum row0=105, o_beats=1, o_sat=0.
- 3-beat window, row1 sums -7, 20, -3, add_psum only on beat0 with psum=-1000, SS_ack tied 1 -> o_psum row1=-990, o_beats=3, MS_ack every cycle.
- Overflow: row2 psum=32760 with add_psum, sum=2047 on a first beat, then sum=-2047 last -> beat0 clamps to 32767; o_psum row2=30720, o_sat[2]=1, other rows o_sat=0.
- Backpressure: result pending with SS_ack=0, 4 non-last beats then a last beat -> non-last beats acked each cycle, last beat MS_ack=0 until SS_ack, then accepted. Old outputs unchanged while held.
- Simultaneous: SS_rdy=1, SS_ack=1 and a last beat accepted the same cycle -> SS_rdy stays 1, outputs replaced next cycle with no bubble. Sustained 1 window/cycle with first=last=1.
- Assert i_rst mid-window (2 of 4 beats done) and with SS_rdy=1 -> all outputs 0 next cycle. A fresh first/last beat then yields only its own sum.

Source files
------------

// File: rtl/sum_stage.sv
// sum_stage: per-row signed saturating psum accumulator between the
// multiply stage and the psum/output stage, with a one-deep result slot.
module sum_stage #(
  parameter int PEROW   = 4,
  parameter int ASUMDWD = 12,
  parameter int PSUMDWD = 16,
  parameter int PPCTLWD = 4,
  parameter int CNTWD   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       MS_rdy,
  output logic                       MS_ack,
  input  logic                       i_first,
  input  logic                       i_last,
  input  logic                       i_add_psum,
  input  logic [PPCTLWD-1:0]         i_ppctl,
  input  logic [PEROW*PSUMDWD-1:0]   i_psum,
  input  logic [PEROW*ASUMDWD-1:0]   i_sum,
  output logic                       SS_rdy,
  input  logic                       SS_ack,
  output logic [PEROW*PSUMDWD-1:0]   o_psum,
  output logic [PEROW-1:0]           o_sat,
  output logic [PPCTLWD-1:0]         o_ppctl,
  output logic [CNTWD-1:0]           o_beats
);

  localparam int TW = PSUMDWD + 2;

  localparam logic signed [TW-1:0] MAXV =
    {{3{1'b0}}, {(PSUMDWD-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV =
    {{3{1'b1}}, {(PSUMDWD-1){1'b0}}};

  logic [PEROW*PSUMDWD-1:0] acc_q;
  logic [PEROW*PSUMDWD-1:0] acc_d;
  logic [PEROW-1:0]         sat_q;
  logic [PEROW-1:0]         sat_d;
  logic [CNTWD-1:0]         cnt_q;
  logic [CNTWD-1:0]         cnt_d;
  logic                     free;
  logic                     accept;
  logic                     load;

  // Only a closing beat needs the output slot; others go straight to acc.
  assign free   = !SS_rdy || SS_ack;
  assign MS_ack = MS_rdy && !i_rst && (!i_last || free);
  assign accept = MS_ack;
  assign load   = accept && i_last;

  for (genvar r = 0; r < PEROW; r++) begin : g_row
    logic [PSUMDWD-1:0]     acc_r;
    logic [PSUMDWD-1:0]     psum_r;
    logic [ASUMDWD-1:0]     sum_r;
    logic signed [TW-1:0]   base;
    logic signed [TW-1:0]   sx;
    logic signed [TW-1:0]   px;
    logic signed [TW-1:0]   t;
    logic                   hi;
    logic                   lo;
    logic [PSUMDWD-1:0]     res;

    assign acc_r  = acc_q[r*PSUMDWD +: PSUMDWD];
    assign psum_r = i_psum[r*PSUMDWD +: PSUMDWD];
    assign sum_r  = i_sum[r*ASUMDWD +: ASUMDWD];

    assign base = i_first ? '0
                : {{2{acc_r[PSUMDWD-1]}}, acc_r};
    assign sx   = {{(TW-ASUMDWD){sum_r[ASUMDWD-1]}}, sum_r};
    assign px   = i_add_psum
                ? {{2{psum_r[PSUMDWD-1]}}, psum_r}
                : '0;
    assign t    = base + sx + px;

    assign hi  = t > MAXV;
    assign lo  = t < MINV;
    assign res = hi ? MAXV[PSUMDWD-1:0]
               : lo ? MINV[PSUMDWD-1:0]
               : t[PSUMDWD-1:0];

    assign acc_d[r*PSUMDWD +: PSUMDWD] = res;
    assign sat_d[r] = (!i_first && sat_q[r]) || hi || lo;
  end

  assign cnt_d = i_first ? CNTWD'(1)
               : (&cnt_q) ? cnt_q
               : cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
      SS_rdy  <= 1'b0;
      o_psum  <= '0;
      o_sat   <= '0;
      o_ppctl <= '0;
      o_beats <= '0;
    end else begin
      if (accept) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
        cnt_q <= cnt_d;
      end
      if (load) begin
        SS_rdy  <= 1'b1;
        o_psum  <= acc_d;
        o_sat   <= sat_d;
        o_ppctl <= i_ppctl;
        o_beats <= cnt_d;
      end else if (SS_ack) begin
        SS_rdy <= 1'b0;
      end
    end
  end

endmodule
